// File: rtl/p_to_s_cp.sv
// Parallel-to-serial symbol streamer with optional cyclic prefix.
// Emits one sample per o_clk rising tick; o_clk is clk divided by 2*DIV.
module p_to_s_cp #(
  parameter int WIDTH      = 10,
  parameter int N          = 64,
  parameter int CP_LEN     = 16,
  parameter int DIV        = 1,
  parameter int OFFSET_BIN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_cp_en,
  input  logic               i_valid,
  input  logic [N*WIDTH-1:0] i_x,
  output logic [WIDTH-1:0]   Y,
  output logic               o_clk,
  output logic               o_next_req,
  output logic               o_sym_start,
  output logic               o_underrun
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [IW-1:0]    LAST     = IW'(N - 1);
  localparam logic [IW-1:0]    CP_START = IW'(N - CP_LEN);
  localparam logic [DW-1:0]    DIV_END  = DW'(DIV - 1);
  localparam logic [WIDTH-1:0] MSB      = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] FLIP     = (OFFSET_BIN != 0) ? MSB : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_CP,
    S_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     div_q;
  logic [WIDTH-1:0]  y_d;
  logic              nreq_d, ss_d;
  logic              cp_on_q, cp_on_d;
  logic              active_q;
  logic              load;
  logic              tick, rise, fall;

  // Samples are stored already in output encoding, so the zero level is 0.
  logic [WIDTH-1:0]  sbuf [N];

  assign tick = (div_q == DIV_END);
  assign rise = tick & ~o_clk;
  assign fall = tick & o_clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      o_clk <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) o_clk <= ~o_clk;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       active_q <= 1'b0;
    else if (i_stop)  active_q <= 1'b0;
    else if (i_start) active_q <= 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    y_d     = Y;
    nreq_d  = o_next_req;
    ss_d    = o_sym_start;
    cp_on_d = cp_on_q;
    load    = 1'b0;
    if (fall) begin
      nreq_d = 1'b0;
      ss_d   = 1'b0;
    end
    if (rise) begin
      unique case (state_q)
        S_IDLE: begin
          y_d = '0;
          if (active_q) begin
            state_d = S_PRIME;
            nreq_d  = 1'b1;
          end
        end
        S_PRIME: load = 1'b1;
        S_CP: begin
          y_d  = sbuf[idx_q];
          ss_d = (idx_q == CP_START);
          if (idx_q == LAST) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_DATA: begin
          y_d  = sbuf[idx_q];
          ss_d = (idx_q == '0) && !cp_on_q;
          if (idx_q != LAST) begin
            idx_d = idx_q + 1'b1;
          end else if (active_q) begin
            // Back-to-back: last sample leaves while the next symbol lands.
            load   = 1'b1;
            nreq_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (load) begin
        cp_on_d = i_cp_en && (CP_LEN != 0);
        if (cp_on_d) begin
          state_d = S_CP;
          idx_d   = CP_START;
        end else begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      Y           <= '0;
      o_next_req  <= 1'b0;
      o_sym_start <= 1'b0;
      o_underrun  <= 1'b0;
      cp_on_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      Y           <= y_d;
      o_next_req  <= nreq_d;
      o_sym_start <= ss_d;
      o_underrun  <= load & ~i_valid;
      cp_on_q     <= cp_on_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) sbuf[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < N; k++)
        sbuf[k] <= i_valid ? (i_x[k*WIDTH +: WIDTH] ^ FLIP) : '0;
    end
  end

endmodule

// File: tb/tb_p_to_s_cp.sv
// Scoreboard bench for p_to_s_cp: symbol-level reference model,
// plus a DIV=3 instance for divider and edge-alignment checks.
module tb_p_to_s_cp;

  localparam int W   = 10;
  localparam int N   = 8;
  localparam int CPL = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           i_start = 1'b0;
  logic           i_stop = 1'b0;
  logic           i_cp_en = 1'b0;
  logic           i_valid = 1'b0;
  logic [N*W-1:0] i_x = '0;

  logic [W-1:0] y, y3;
  logic         oclk, nreq, ss, und;
  logic         oclk3, nreq3, ss3, und3;

  p_to_s_cp #(.WIDTH(W), .N(N), .CP_LEN(CPL), .DIV(1), .OFFSET_BIN(1)) u_dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop),
    .i_cp_en(i_cp_en), .i_valid(i_valid), .i_x(i_x),
    .Y(y), .o_clk(oclk), .o_next_req(nreq),
    .o_sym_start(ss), .o_underrun(und)
  );

  p_to_s_cp #(.WIDTH(W), .N(N), .CP_LEN(CPL), .DIV(3), .OFFSET_BIN(1)) u_div3 (
    .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop),
    .i_cp_en(i_cp_en), .i_valid(i_valid), .i_x(i_x),
    .Y(y3), .o_clk(oclk3), .o_next_req(nreq3),
    .o_sym_start(ss3), .o_underrun(und3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic         first;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_und = 0;
  int   got_und = 0;
  bit   mon_en = 1'b0;
  bit   running = 1'b0;
  bit   arm = 1'b0;

  logic [W-1:0] sx [N];
  logic         sv, scp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // mode 0: ramp no prefix, 1: ramp with prefix, 2: random
  task automatic set_sym(input int mode);
    for (int k = 0; k < N; k++)
      sx[k] = (mode < 2) ? W'(k + 1) : W'($urandom_range(0, 2**W - 1));
    sv  = (mode < 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    scp = (mode < 2) ? mode[0] : 1'(($urandom_range(0, 1)));
    for (int k = 0; k < N; k++) i_x[k*W +: W] = sx[k];
    i_valid = sv;
    i_cp_en = scp;
  endtask

  // Expected serial stream of the symbol currently presented.
  task automatic push_sym();
    exp_t e;
    int   len, off, k;
    off = scp ? CPL : 0;
    len = N + off;
    for (int j = 0; j < len; j++) begin
      k       = (j - off + N) % N;
      e.y     = sv ? W'((int'(sx[k]) + 2**(W-1)) % 2**W) : '0;
      e.first = (j == 0);
      q.push_back(e);
    end
    if (!sv) exp_und++;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (nreq) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Main monitor: samples appear on o_clk rises once the stream is primed.
  logic oclk_p = 1'b0;
  logic und_p = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      running = 1'b0;
      arm     = 1'b0;
    end else begin
      if (und) begin
        got_und++;
        chk("underrun_width", 32'(und_p), 32'd0);
      end
      if (oclk && !oclk_p) begin
        if (running) begin
          if (q.size() == 0) begin
            chk("idle_y_after_stop", 32'(y), 32'd0);
            chk("no_req_after_stop", 32'(nreq), 32'd0);
            running = 1'b0;
          end else begin
            e = q.pop_front();
            chk("y", 32'(y), 32'(e.y));
            chk("sym_start", 32'(ss), 32'(e.first));
          end
        end else if (arm) begin
          arm     = 1'b0;
          running = 1'b1;
        end else if (nreq) begin
          arm = 1'b1;
        end
      end
    end
    oclk_p = oclk;
    und_p  = und;
  end

  // DIV=3 monitor: half period of 3 clk, Y moves only on o_clk 0->1.
  int         c3 = 0;
  bit         seen3 = 1'b0;
  logic       o3p = 1'b0;
  logic       rp = 1'b0;
  logic [W-1:0] y3p = '0;
  always @(negedge clk) begin
    if (reset && rp) begin
      c3++;
      if (oclk3 != o3p) begin
        if (seen3) chk("div3_half_period", 32'(c3), 32'd3);
        seen3 = 1'b1;
        c3    = 0;
      end
      if (y3 != y3p) chk("div3_y_on_rise", {30'd0, o3p, oclk3}, 32'd1);
    end else begin
      c3    = 0;
      seen3 = 1'b0;
    end
    o3p = oclk3;
    y3p = y3;
    rp  = reset;
  end

  initial begin
    bit ok;
    int mode, nsym, tog, reqs, bad;
    logic prev;

    set_sym(0);
    #12;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_oclk", 32'(oclk), 32'd0);
    chk("rst_next_req", 32'(nreq), 32'd0);
    chk("rst_sym_start", 32'(ss), 32'd0);
    chk("rst_underrun", 32'(und), 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    for (int ep = 0; ep < 6; ep++) begin
      mode = (ep < 2) ? ep : 2;
      nsym = (ep < 2) ? 3 : $urandom_range(3, 5);
      set_sym(mode);
      pulse_start();
      for (int s = 0; s < nsym; s++) begin
        wait_req(ok);
        chk("req_seen", 32'(ok), 32'd1);
        if (!ok) break;
        push_sym();
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (mode == 2) set_sym(2);
        if (ep == 2 && s == 0) begin
          sv      = 1'b0;
          i_valid = 1'b0;
        end
        if (ep == 4 && s == 1) pulse_start();
        if (s == nsym - 1) begin
          repeat ($urandom_range(0, 8)) @(negedge clk);
          i_stop = 1'b1;
          if (ep == 3) i_start = 1'b1;
          @(negedge clk);
          i_stop  = 1'b0;
          i_start = 1'b0;
        end
      end
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!running && q.size() == 0) begin
          ok = 1'b1;
          break;
        end
      end
      chk("stream_drained", 32'(ok), 32'd1);
      tog  = 0;
      reqs = 0;
      prev = oclk;
      repeat (12) begin
        @(negedge clk);
        if (oclk != prev) tog++;
        prev = oclk;
        if (nreq) reqs++;
      end
      chk("idle_oclk_toggles", 32'(tog), 32'd12);
      chk("idle_no_req", 32'(reqs), 32'd0);
      chk("idle_y", 32'(y), 32'd0);
      q.delete();
    end
    chk("underrun_count", 32'(got_und), 32'(exp_und));

    // Asynchronous reset in the middle of a symbol.
    mon_en = 1'b0;
    @(negedge clk);
    set_sym(0);
    pulse_start();
    wait_req(ok);
    chk("pre_reset_req", 32'(ok), 32'd1);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_y", 32'(y), 32'd0);
    chk("async_rst_oclk", 32'(oclk), 32'd0);
    chk("async_rst_next_req", 32'(nreq), 32'd0);
    chk("async_rst_sym_start", 32'(ss), 32'd0);
    chk("async_rst_underrun", 32'(und), 32'd0);
    chk("async_rst_div3_y", 32'(y3), 32'd0);
    chk("async_rst_div3_oclk", 32'(oclk3), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (nreq || y != '0) bad++;
    end
    chk("no_restart_without_start", 32'(bad), 32'd0);
    pulse_start();
    wait_req(ok);
    chk("restart_req", 32'(ok), 32'd1);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
